// File: rtl/vgalb_ctrl_if.sv
// ----------------------------------------------------------------------------
// vgalb_ctrl_if
// Purpose : groups the scanout read port and the pixel write port of the
//           line-buffer sequencer into one bundle.
// Signals :
//   rd_req / rd_addr          scanout read request and address
//   rd_gnt                    read accepted this cycle
//   rd_vld / rd_data          read data return, RD_LAT cycles after rd_gnt
//   wr_req / wr_addr / wr_data pixel write request, address and data
//   wr_gnt                    write performed this cycle
// Modports:
//   master : the requesting side (scanout + pixel writer)
//   slave  : the sequencer (vgalb_ctrl)
// ----------------------------------------------------------------------------
interface vgalb_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 24
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_vld, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_vld, rd_data, wr_gnt
  );
endinterface

// File: rtl/vgalb_ctrl.sv
// ----------------------------------------------------------------------------
// vgalb_ctrl
// Purpose : sequencer/arbiter for one single-port line-buffer RAM with a
//           registered read of RD_LAT cycles. Shares the RAM between the
//           scanout reader, the pixel writer and an internal clear engine.
//           One RAM access per cycle; priority is
//           forced write > read > write > clear.
// Ports   :
//   sys_clk_i    system clock, rising edge
//   sys_rst_i    asynchronous active-high reset
//   rd_clr_i     (VGALB_CLR_ON_READ_EN only) clear-on-read for this read
//   bus          read/write request bundle (vgalb_ctrl_if.slave)
//   clr_start_i  start line clear (pulse, sampled only in IDLE)
//   clr_base_i   first clear address
//   clr_len_i    number of words to clear, 0..1<<AW
//   clr_value_i  background value written by the clear
//   clr_busy_o   clear engine running
//   clr_done_o   one-cycle pulse when the clear finishes
//   ram_a_o / ram_d_o / ram_we_o / ram_q_i   RAM port
// Config  :
//   VGALB_CLR_ON_READ_EN  adds rd_clr_i; a read granted with rd_clr_i=1
//                         writes the latched clear value back to the same
//                         address on the following cycle at top priority.
// ----------------------------------------------------------------------------
module vgalb_ctrl #(
  parameter int AW        = 10,
  parameter int DW        = 24,
  parameter int RD_LAT    = 2,
  parameter int WR_STARVE = 4
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
`ifdef VGALB_CLR_ON_READ_EN
  input  logic          rd_clr_i,
`endif
  vgalb_ctrl_if.slave   bus,
  input  logic          clr_start_i,
  input  logic [AW-1:0] clr_base_i,
  input  logic [AW:0]   clr_len_i,
  input  logic [DW-1:0] clr_value_i,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic [AW-1:0] ram_a_o,
  output logic [DW-1:0] ram_d_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_q_i
);

  localparam int SW = $clog2(WR_STARVE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} clrState_e;

  clrState_e         state_q;
  logic [AW-1:0]     clrAddr_q;
  logic [AW:0]       clrRem_q;
  logic [DW-1:0]     clrValue_q;
  logic [SW-1:0]     starveCnt_q;
  logic [RD_LAT-1:0] vld_q;

  logic              pendWr;
  logic [AW-1:0]     pendAddr;
  logic              forceWr;
  logic              rdGnt;
  logic              wrGnt;
  logic              clrWr;

  // A write that has waited through WR_STARVE consecutive read grants takes
  // the slot from the reader. Grants are masked during reset so the RAM port
  // goes quiet immediately, not at the next edge.
  assign forceWr = bus.wr_req && (starveCnt_q == SW'(WR_STARVE));
  assign rdGnt   = !sys_rst_i && !pendWr && !forceWr && bus.rd_req;
  assign wrGnt   = !sys_rst_i && !pendWr && bus.wr_req && (forceWr || !bus.rd_req);
  assign clrWr   = !sys_rst_i && !pendWr && (state_q == RUN) && !bus.rd_req && !bus.wr_req;

`ifdef VGALB_CLR_ON_READ_EN
  logic          pendVld_q;
  logic [AW-1:0] pendAddr_q;

  // Remember a clear-on-read so the same address gets the background value
  // on the very next cycle, ahead of every other requester.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      pendVld_q  <= 1'b0;
      pendAddr_q <= '0;
    end else begin
      pendVld_q  <= rdGnt && rd_clr_i;
      pendAddr_q <= bus.rd_addr;
    end
  end

  assign pendWr   = pendVld_q;
  assign pendAddr = pendAddr_q;
`else
  assign pendWr   = 1'b0;
  assign pendAddr = '0;
`endif

  // RAM port mux. Exactly one source owns the port in any cycle; with no
  // access the address and data rest at zero.
  always_comb begin
    ram_a_o  = '0;
    ram_d_o  = '0;
    ram_we_o = 1'b0;
    if (!sys_rst_i && pendWr) begin
      ram_a_o  = pendAddr;
      ram_d_o  = clrValue_q;
      ram_we_o = 1'b1;
    end else if (wrGnt) begin
      ram_a_o  = bus.wr_addr;
      ram_d_o  = bus.wr_data;
      ram_we_o = 1'b1;
    end else if (rdGnt) begin
      ram_a_o  = bus.rd_addr;
    end else if (clrWr) begin
      ram_a_o  = clrAddr_q;
      ram_d_o  = clrValue_q;
      ram_we_o = 1'b1;
    end
  end

  // Starvation counter: counts reads that won while a write was waiting.
  // Any cycle without a pending write, or a served write, starts it over.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      starveCnt_q <= '0;
    end else if (!bus.wr_req || wrGnt) begin
      starveCnt_q <= '0;
    end else if (rdGnt && (starveCnt_q != SW'(WR_STARVE))) begin
      starveCnt_q <= starveCnt_q + SW'(1);
    end
  end

  // Read-valid pipeline mirrors the RAM latency; reset flushes it so reads
  // in flight at reset never report valid.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rdGnt;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Clear engine. Latches its job in IDLE, then steals only the slots
  // nobody else wants; the address wraps so a full-length clear covers the
  // whole RAM from any base. A zero-length job goes straight to DONE.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q    <= IDLE;
      clrAddr_q  <= '0;
      clrRem_q   <= '0;
      clrValue_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            clrValue_q <= clr_value_i;
            clrAddr_q  <= clr_base_i;
            clrRem_q   <= clr_len_i;
            state_q    <= (clr_len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (clrWr) begin
            clrAddr_q <= clrAddr_q + AW'(1);
            clrRem_q  <= clrRem_q - (AW+1)'(1);
            if (clrRem_q == (AW+1)'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_gnt  = rdGnt;
  assign bus.wr_gnt  = wrGnt;
  assign bus.rd_vld  = vld_q[RD_LAT-1];
  assign bus.rd_data = ram_q_i;
  assign clr_busy_o  = (state_q == RUN);
  assign clr_done_o  = (state_q == DONE);

endmodule

// File: tb/tb_vgalb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vgalb_ctrl
// Purpose : directed self-checking bench for vgalb_ctrl with a behavioural
//           1024x24 RAM with a 2-cycle registered read.
// ----------------------------------------------------------------------------
module tb_vgalb_ctrl;

  localparam int AW = 10;
  localparam int DW = 24;

  logic          sysClk;
  logic          sysRst;
  logic          clrStart;
  logic [AW-1:0] clrBase;
  logic [AW:0]   clrLen;
  logic [DW-1:0] clrValue;
  logic          clrBusy;
  logic          clrDone;
  logic [AW-1:0] ramA;
  logic [DW-1:0] ramD;
  logic          ramWe;
  logic [DW-1:0] ramQ;
  logic [DW-1:0] ramQ1;
`ifdef VGALB_CLR_ON_READ_EN
  logic          rdClr;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compared;
  int mismatched;

  vgalb_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  vgalb_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .WR_STARVE(4)) dut (
    .sys_clk_i   (sysClk),
    .sys_rst_i   (sysRst),
`ifdef VGALB_CLR_ON_READ_EN
    .rd_clr_i    (rdClr),
`endif
    .bus         (bus.slave),
    .clr_start_i (clrStart),
    .clr_base_i  (clrBase),
    .clr_len_i   (clrLen),
    .clr_value_i (clrValue),
    .clr_busy_o  (clrBusy),
    .clr_done_o  (clrDone),
    .ram_a_o     (ramA),
    .ram_d_o     (ramD),
    .ram_we_o    (ramWe),
    .ram_q_i     (ramQ)
  );

  // 100 MHz-style free running clock
  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // Behavioural RAM: read captured at the edge, data out one edge later;
  // the array is updated after the read sample so a write is seen next cycle.
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  end

  always @(posedge sysClk) begin
    ramQ1 <= mem[ramA];
    ramQ  <= ramQ1;
    if (ramWe) mem[ramA] = ramD;
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the request bundle, then let combinational grants settle
  task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra,
                               input logic wq, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
    bus.rd_req  = rq;
    bus.rd_addr = ra;
    bus.wr_req  = wq;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge sysClk);
    #1;
  endtask

  task automatic startClear(input logic [AW-1:0] base, input logic [AW:0] len, input logic [DW-1:0] val);
    clrStart = 1'b1;
    clrBase  = base;
    clrLen   = len;
    clrValue = val;
    nextCycle();
    clrStart = 1'b0;
  endtask

  initial begin
    int writes, collide, gnts, vlds, dataErr, doneAt, cyc;

    compared   = 0;
    mismatched = 0;
    sysRst     = 1'b1;
    clrStart   = 1'b0;
    clrBase    = '0;
    clrLen     = '0;
    clrValue   = '0;
`ifdef VGALB_CLR_ON_READ_EN
    rdClr      = 1'b0;
`endif
    applyStimulus(1'b1, 10'd9, 1'b1, 10'd8, 24'h555555);

    // reset state, with requests asserted
    nextCycle();
    checkOutput("rst_rd_gnt", bus.rd_gnt, 0);
    checkOutput("rst_wr_gnt", bus.wr_gnt, 0);
    checkOutput("rst_ram_we", ramWe, 0);
    checkOutput("rst_ram_a", ramA, 0);
    checkOutput("rst_clr_busy", clrBusy, 0);
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    nextCycle();
    sysRst = 1'b0;
    nextCycle();

    // 1: write 5 <= ABCDEF then read it back
    applyStimulus(1'b0, 10'd0, 1'b1, 10'd5, 24'hABCDEF);
    checkOutput("t1_wr_gnt", bus.wr_gnt, 1);
    checkOutput("t1_wr_ram_a", ramA, 5);
    checkOutput("t1_wr_ram_d", ramD, 24'hABCDEF);
    nextCycle();
    applyStimulus(1'b1, 10'd5, 1'b0, 10'd0, 24'h0);
    checkOutput("t1_rd_gnt", bus.rd_gnt, 1);
    checkOutput("t1_rd_we", ramWe, 0);
    nextCycle();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    checkOutput("t1_vld_early", bus.rd_vld, 0);
    nextCycle();
    checkOutput("t1_rd_vld", bus.rd_vld, 1);
    checkOutput("t1_rd_data", bus.rd_data, 24'hABCDEF);
    nextCycle();
    checkOutput("t1_vld_after", bus.rd_vld, 0);

    // 2: both requesters held -> 4 reads then 1 forced write, repeating
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 10'd300, 1'b1, 10'd200, 24'(j));
      checkOutput($sformatf("t2_rd_gnt_%0d", j), bus.rd_gnt, (j % 5 != 4) ? 1 : 0);
      checkOutput($sformatf("t2_wr_gnt_%0d", j), bus.wr_gnt, (j % 5 == 4) ? 1 : 0);
      nextCycle();
    end
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    nextCycle();
    nextCycle();
    nextCycle();

    // 3: clear 8 words from 1020 with wrap, no traffic
    startClear(10'd1020, 11'd8, 24'h123456);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("t3_busy_%0d", k), clrBusy, 1);
      checkOutput($sformatf("t3_we_%0d", k), ramWe, 1);
      checkOutput($sformatf("t3_a_%0d", k), ramA, (1020 + k) % 1024);
      checkOutput($sformatf("t3_d_%0d", k), ramD, 24'h123456);
      nextCycle();
    end
    checkOutput("t3_done", clrDone, 1);
    checkOutput("t3_busy_end", clrBusy, 0);
    checkOutput("t3_we_end", ramWe, 0);
    nextCycle();
    checkOutput("t3_done_pulse", clrDone, 0);
    checkOutput("t3_mem_1023", mem[1023], 24'h123456);
    checkOutput("t3_mem_3", mem[3], 24'h123456);
    checkOutput("t3_mem_4", mem[4], 0);
    checkOutput("t3_mem_1019", mem[1019], 0);

    // 4: clear 16 words while reads alternate; clear uses only idle slots
    writes = 0; collide = 0; gnts = 0; vlds = 0; dataErr = 0; doneAt = -1; cyc = 0;
    startClear(10'd100, 11'd16, 24'h0F0F0F);
    while (doneAt < 0 && cyc < 80) begin
      applyStimulus((cyc % 2) == 0, 10'd5, 1'b0, 10'd0, 24'h0);
      if (ramWe) writes++;
      if (ramWe && bus.rd_req) collide++;
      if (bus.rd_gnt) gnts++;
      if (bus.rd_vld) begin
        vlds++;
        if (bus.rd_data !== 24'hABCDEF) dataErr++;
      end
      if (clrDone) doneAt = cyc;
      nextCycle();
      cyc++;
    end
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    for (int k = 0; k < 3; k++) begin
      if (bus.rd_vld) begin
        vlds++;
        if (bus.rd_data !== 24'hABCDEF) dataErr++;
      end
      nextCycle();
    end
    checkOutput("t4_done_cycle", doneAt, 32);
    checkOutput("t4_clear_writes", writes, 16);
    checkOutput("t4_collisions", collide, 0);
    checkOutput("t4_rd_gnts", gnts, 17);
    checkOutput("t4_rd_vlds", vlds, 17);
    checkOutput("t4_rd_data_err", dataErr, 0);
    checkOutput("t4_mem_100", mem[100], 24'h0F0F0F);
    checkOutput("t4_mem_115", mem[115], 24'h0F0F0F);
    checkOutput("t4_mem_116", mem[116], 0);

    // 5a: zero-length clear finishes next cycle without writing
    clrStart = 1'b1;
    clrBase  = 10'd50;
    clrLen   = 11'd0;
    clrValue = 24'h777777;
    #1;
    checkOutput("t5_len0_we", ramWe, 0);
    nextCycle();
    clrStart = 1'b0;
    checkOutput("t5_len0_done", clrDone, 1);
    checkOutput("t5_len0_busy", clrBusy, 0);
    checkOutput("t5_len0_we2", ramWe, 0);
    nextCycle();
    checkOutput("t5_len0_pulse", clrDone, 0);
    checkOutput("t5_len0_mem", mem[50], 0);

    // 5b: a second start during RUN is ignored
    startClear(10'd400, 11'd3, 24'h111111);
    clrStart = 1'b1;
    clrBase  = 10'd600;
    clrLen   = 11'd5;
    clrValue = 24'h222222;
    #1;
    checkOutput("t5_run_a0", ramA, 400);
    checkOutput("t5_run_d0", ramD, 24'h111111);
    nextCycle();
    clrStart = 1'b0;
    checkOutput("t5_run_a1", ramA, 401);
    nextCycle();
    checkOutput("t5_run_a2", ramA, 402);
    nextCycle();
    checkOutput("t5_run_done", clrDone, 1);
    nextCycle();
    nextCycle();
    checkOutput("t5_run_idle", clrBusy, 0);
    checkOutput("t5_mem_600", mem[600], 0);
    checkOutput("t5_mem_402", mem[402], 24'h111111);

    // 6: reset mid-clear with two reads in flight
    startClear(10'd700, 11'd20, 24'h333333);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 10'd5, 1'b0, 10'd0, 24'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 10'd5, 1'b1, 10'd6, 24'h999999);
    sysRst = 1'b1;
    #1;
    checkOutput("t6_rd_gnt", bus.rd_gnt, 0);
    checkOutput("t6_wr_gnt", bus.wr_gnt, 0);
    checkOutput("t6_ram_we", ramWe, 0);
    checkOutput("t6_rd_vld", bus.rd_vld, 0);
    checkOutput("t6_clr_busy", clrBusy, 0);
    checkOutput("t6_clr_done", clrDone, 0);
    checkOutput("t6_ram_a", ramA, 0);
    checkOutput("t6_ram_d", ramD, 0);
    nextCycle();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    sysRst = 1'b0;
    vlds = 0; writes = 0; gnts = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.rd_vld) vlds++;
      if (ramWe) writes++;
      if (clrBusy) gnts++;
      nextCycle();
    end
    checkOutput("t6_vld_after", vlds, 0);
    checkOutput("t6_we_after", writes, 0);
    checkOutput("t6_busy_after", gnts, 0);

`ifdef VGALB_CLR_ON_READ_EN
    // clear-on-read writes the latched background value back next cycle
    startClear(10'd0, 11'd0, 24'h654321);
    nextCycle();
    rdClr = 1'b1;
    applyStimulus(1'b1, 10'd7, 1'b0, 10'd0, 24'h0);
    checkOutput("cor_rd_gnt", bus.rd_gnt, 1);
    nextCycle();
    rdClr = 1'b0;
    applyStimulus(1'b1, 10'd9, 1'b1, 10'd8, 24'h1);
    checkOutput("cor_rd_blocked", bus.rd_gnt, 0);
    checkOutput("cor_wr_blocked", bus.wr_gnt, 0);
    checkOutput("cor_we", ramWe, 1);
    checkOutput("cor_a", ramA, 7);
    checkOutput("cor_d", ramD, 24'h654321);
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 24'h0);
    nextCycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
